uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DEFAULT_DIV, default 106, meaning the bit period in clk cycles used when cfg_div is 0.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO depth in bytes; only powers of two are legal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ser_rx, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 The block SHALL have port cfg_div, input, 16 bits: bit period in clk cycles; 0 selects DEFAULT_DIV; values 1-3 are treated as 4.
REQ-007 The block SHALL have port out_data, output, 8 bits: the FIFO head byte.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the byte; a pop occurs when out_valid and out_ready are both high.
REQ-010 The block SHALL have port frame_err, output, 1 bit: 1-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: 1-cycle pulse when a byte is dropped because the FIFO is full.
REQ-012 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-013 ser_rx SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized signal rx_s.
REQ-014 The effective divisor D SHALL be latched from cfg_div (with the REQ-006 rules applied) in the cycle the start edge is detected; cfg_div changes mid-frame SHALL have no effect on the current frame.
REQ-015 The state machine SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-016 In IDLE, a 1->0 transition of rx_s detected in cycle T SHALL cause a transition to START.
REQ-017 In START, rx_s SHALL be sampled at cycle T+floor(D/2): a 0 SHALL cause a transition to DATA; a 1 is a false start and SHALL cause a return to IDLE with no output and no flag.
REQ-018 In DATA, data bit i (i=0..7) SHALL be sampled at cycle T+floor(D/2)+(i+1)*D and shifted in LSB first; the bit counter SHALL wrap from 7 to STOP.
REQ-019 In STOP, rx_s SHALL be sampled at cycle T+floor(D/2)+9*D.
REQ-020 If the stop sample is 1, the byte SHALL be pushed and the machine SHALL return to IDLE.
REQ-021 If the stop sample is 0, the byte SHALL be discarded, frame_err SHALL pulse in the following cycle, and the machine SHALL enter WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL return to IDLE only after rx_s has been 1 for one full sample; a held break SHALL produce exactly one frame_err.
REQ-023 A pushed byte SHALL appear on out_data with out_valid high in the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-024 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 A push into a full FIFO with no pop in the same cycle SHALL drop the new byte and pulse overrun for 1 cycle; FIFO contents SHALL be unchanged.
REQ-027 A simultaneous push and pop when full SHALL accept the push with no overrun, and fifo_level SHALL stay at FIFO_DEPTH.
REQ-028 A simultaneous push and pop when non-full and non-empty SHALL leave fifo_level unchanged.
REQ-029 A pop when empty SHALL be ignored.
REQ-030 The sample-point counter SHALL be 16 bits and SHALL reload D-1 after each sample; no sample point SHALL drift by more than 0 cycles from REQ-017 through REQ-019.

Reset
REQ-031 While reset=1 at a rising clk edge, the state SHALL become IDLE; the synchronizer flops SHALL be set to 1; the FIFO pointers and fifo_level SHALL become 0; out_valid, frame_err and overrun SHALL become 0; out_data SHALL become 0x00.
REQ-032 A reset mid-frame SHALL abandon the frame with no push and no flag; the next start edge after reset is released SHALL be received normally.

Verification
REQ-033 The bench SHALL drive ser_rx with 0x55 at D=106 and out_ready=1, and SHALL check that out_data=0x55 and out_valid rises exactly 2+53+954+1 cycles after the ser_rx falling edge.
REQ-034 The bench SHALL drive back-to-back 'A'(0x41) then 0x0A with no idle gap, and SHALL check that both are received in order with no frame_err.
REQ-035 The bench SHALL drive 0xA5 with the stop bit forced to 0, then hold low for 2000 cycles, then send 0xFF, and SHALL check one frame_err pulse, no 0xA5 push, and 0xFF received.
REQ-036 The bench SHALL drive a 20-cycle low glitch on idle ser_rx at D=106, and SHALL check no push, no frame_err, and the state back in IDLE.
REQ-037 The bench SHALL send 5 bytes 0x01-0x05 with out_ready=0, and SHALL check fifo_level=4, an overrun pulse after byte 5, then reads of 0x01,0x02,0x03,0x04 and fifo_level=0.
REQ-038 The bench SHALL assert reset during bit 4 of 0x3C, release it, then send 0xC3 with cfg_div=0, and SHALL check only 0xC3 is received, using D=DEFAULT_DIV.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchronizer, per-frame latched divisor and a small byte FIFO.
// Byte valid the cycle after the stop sample; out_ready backpressures the FIFO, and a full FIFO drops the new byte and pulses overrun.
module uart_rx #(
  parameter int DEFAULT_DIV = 106,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ser_rx,
  input  logic [15:0]                  cfg_div,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t      state, state_nxt;
  logic        sync1, rx_s, rx_d;
  logic [15:0] div_eff, div_q, cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        sample, start_edge, push, ferr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_comb begin
    if (cfg_div == 16'd0)     div_eff = 16'(DEFAULT_DIV);
    else if (cfg_div < 16'd4) div_eff = 16'd4;
    else                      div_eff = cfg_div;
  end

  assign sample     = (cnt == 16'd0);
  assign start_edge = rx_d & ~rx_s;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:      if (start_edge) state_nxt = START;
      START:     if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (sample && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      // cnt only runs down while the line is high, so this needs a full bit of idle
      WAIT_IDLE: if (sample && rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_edge) begin
            div_q   <= div_eff;
            cnt     <= (div_eff >> 1) - 16'd1;
            bit_idx <= '0;
          end
        end
        START, STOP: cnt <= sample ? div_q - 16'd1 : cnt - 16'd1;
        DATA: begin
          if (sample) begin
            cnt     <= div_q - 16'd1;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        WAIT_IDLE: cnt <= rx_s ? cnt - 16'd1 : div_q - 16'd1;
        default: ;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, do_push, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still take the byte
  assign do_push   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      frame_err <= ferr_set;
      overrun   <= drop;
    end
  end

endmodule
